// File: rtl/skid_fifo.sv
// Elastic valid/ready buffer: registered head entry plus a circular RAM.
// Ports: clk, rst_n, flush, up_valid/up_ready/up_data, down_valid/down_ready/down_data, count, almost_full.
module skid_fifo #(
  parameter int width    = 8,
  parameter int depth    = 4,
  parameter int af_level = 3,
  localparam int cw      = $clog2(depth + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [width-1:0] up_data,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [width-1:0] down_data,
  output logic [cw-1:0]    count,
  output logic             almost_full
);

  localparam int RD = depth - 1;
  localparam int PW = (RD > 1) ? $clog2(RD) : 1;

  logic [width-1:0] ram_q [RD];
  logic [width-1:0] data_q;
  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    rp_q, rp_d;
  logic [cw-1:0]    count_q, count_d;
  logic [cw-1:0]    ram_cnt;
  logic             ready_q, valid_q, af_q;
  logic             push, pop, bypass;
  logic             ram_wr, ram_rd;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(RD - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    push    = up_valid & ready_q;
    pop     = valid_q & down_ready;
    ram_cnt = count_q - cw'(valid_q);
    // Head slot is free (or freed now) and nothing queued behind it.
    bypass  = push & (ram_cnt == '0)
            & (~valid_q | pop);
    ram_wr  = push & ~bypass;
    ram_rd  = pop & (ram_cnt != '0);
    count_d = count_q + cw'(push) - cw'(pop);
    wp_d    = ram_wr ? inc(wp_q) : wp_q;
    rp_d    = ram_rd ? inc(rp_q) : rp_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      count_q <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      af_q    <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
    end else begin
      count_q <= count_d;
      valid_q <= (count_d != '0);
      ready_q <= (count_d < cw'(depth));
      af_q    <= (count_d >= cw'(af_level));
      wp_q    <= wp_d;
      rp_q    <= rp_d;
    end
  end

  // Payload storage is never reset; valid_q qualifies it.
  always_ff @(posedge clk) begin
    if (rst_n && !flush) begin
      if (ram_wr) ram_q[wp_q] <= up_data;
      if (bypass) data_q <= up_data;
      else if (ram_rd) data_q <= ram_q[rp_q];
    end
  end

  assign up_ready    = ready_q;
  assign down_valid  = valid_q;
  assign down_data   = data_q;
  assign count       = count_q;
  assign almost_full = af_q;

endmodule

// File: tb/tb_skid_fifo.sv
// Self-checking bench for skid_fifo with a queue scoreboard.
// Covers reset, fill, drain, stream, flush and depth/width variants.
module tb_skid_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       uv = 1'b0;
  logic [7:0] ud = '0;
  logic       dr = 1'b0;
  logic       ur, dv, af;
  logic [7:0] dd;
  logic [2:0] cnt;

  logic       b_uv = 1'b0, b_dr = 1'b0;
  logic [0:0] b_ud = '0;
  logic       b_ur, b_dv, b_af;
  logic [0:0] b_dd;
  logic [1:0] b_cnt;

  logic        c_uv = 1'b0, c_dr = 1'b0;
  logic [63:0] c_ud = '0;
  logic        c_ur, c_dv, c_af;
  logic [63:0] c_dd;
  logic [2:0]  c_cnt;

  skid_fifo u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .up_valid(uv), .up_ready(ur), .up_data(ud),
    .down_valid(dv), .down_ready(dr), .down_data(dd),
    .count(cnt), .almost_full(af)
  );

  skid_fifo #(.width(1), .depth(2), .af_level(2)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .up_valid(b_uv), .up_ready(b_ur), .up_data(b_ud),
    .down_valid(b_dv), .down_ready(b_dr), .down_data(b_dd),
    .count(b_cnt), .almost_full(b_af)
  );

  skid_fifo #(.width(64), .depth(7), .af_level(7)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .up_valid(c_uv), .up_ready(c_ur), .up_data(c_ud),
    .down_valid(c_dv), .down_ready(c_dr), .down_data(c_dd),
    .count(c_cnt), .almost_full(c_af)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0]  q [$];
  logic [63:0] qb [$];
  logic [63:0] qc [$];

  // Model update for the main instance, then one clock.
  task automatic adv();
    bit push, pop;
    if (!rst_n || flush) q.delete();
    else begin
      pop  = (q.size() != 0) && dr;
      push = uv && (q.size() < 4);
      if (pop) void'(q.pop_front());
      if (push) q.push_back(ud);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    adv(); adv();
    checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", cnt); end
    checks++; if (dv !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", dv); end
    checks++; if (ur !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ur); end
    checks++; if (af !== 1'b0) begin errors++; $display("FAIL reset_af got %b want 0", af); end
    checks++; if (b_dv !== 1'b0 || c_dv !== 1'b0) begin errors++; $display("FAIL reset_valid_bc got %b%b want 00", b_dv, c_dv); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    uv = 1'b1; ud = 8'hA5; dr = 1'b1;
    adv();
    uv = 1'b0;
    checks++; if (dv !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", dv); end
    checks++; if (dd !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", dd); end
    checks++; if (cnt !== 3'd1) begin errors++; $display("FAIL single_count got %0d want 1", cnt); end
    adv();
    checks++; if (cnt !== 3'd0 || dv !== 1'b0) begin errors++; $display("FAIL single_drain got cnt %0d dv %b want 0 0", cnt, dv); end
  endtask

  task automatic test_fill();
    logic [7:0] v = 8'h01;
    bit acc;
    dr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      uv = 1'b1; ud = v;
      acc = q.size() < 4;
      adv();
      if (acc) v++;
      checks++; if (cnt !== 3'(q.size())) begin errors++; $display("FAIL fill_count got %0d want %0d", cnt, q.size()); end
      checks++; if (af !== (q.size() >= 3)) begin errors++; $display("FAIL fill_af got %b want %b", af, q.size() >= 3); end
    end
    checks++; if (cnt !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", cnt); end
    checks++; if (ur !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", ur); end
    checks++; if (af !== 1'b1) begin errors++; $display("FAIL full_af got %b want 1", af); end
    checks++; if (dd !== 8'h01) begin errors++; $display("FAIL full_head got %h want 01", dd); end
  endtask

  task automatic test_drain();
    bit pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] expv [3] = '{8'h01, 8'h02, 8'h03};
    logic [7:0] held;
    int n = 0;
    int guard = 0;
    uv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      dr = pat[k];
      held = dd;
      if (dr) begin
        checks++; if (dd !== expv[n] || dd !== q[0]) begin errors++; $display("FAIL drain_data got %h want %h", dd, expv[n]); end
        n++;
      end
      adv();
      if (k == 0) begin
        checks++; if (ur !== 1'b1) begin errors++; $display("FAIL drain_ready got %b want 1", ur); end
      end
      if (!pat[k]) begin
        checks++; if (dd !== held) begin errors++; $display("FAIL stall_data got %h want %h", dd, held); end
      end
    end
    dr = 1'b1;
    while (q.size() != 0 && guard < 20) begin
      checks++; if (dd !== q[0]) begin errors++; $display("FAIL drain_tail got %h want %h", dd, q[0]); end
      adv(); guard++;
    end
    checks++; if (dv !== 1'b0) begin errors++; $display("FAIL drain_empty got %b want 0", dv); end
  endtask

  task automatic test_simul();
    dr = 1'b0; uv = 1'b1;
    ud = 8'h10; adv();
    ud = 8'h11; adv();
    checks++; if (cnt !== 3'd2) begin errors++; $display("FAIL simul_pre got %0d want 2", cnt); end
    dr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ud = 8'h20 + 8'(i);
      checks++; if (dd !== q[0]) begin errors++; $display("FAIL simul_data got %h want %h", dd, q[0]); end
      adv();
      checks++; if (cnt !== 3'd2) begin errors++; $display("FAIL simul_count got %0d want 2", cnt); end
    end
    uv = 1'b0;
    while (q.size() != 0) begin
      checks++; if (dd !== q[0]) begin errors++; $display("FAIL simul_tail got %h want %h", dd, q[0]); end
      adv();
    end
  endtask

  task automatic test_random();
    int got = 0;
    int cyc = 0;
    bit acc = 1'b1;
    while (got < 200 && cyc < 5000) begin
      dr = 1'($urandom_range(0, 1));
      if (acc || !uv) begin
        uv = ($urandom_range(0, 3) != 0);
        ud = 8'($urandom);
      end
      checks++; if (cnt !== 3'(q.size())) begin errors++; $display("FAIL rand_count got %0d want %0d", cnt, q.size()); end
      checks++; if (ur !== (q.size() < 4)) begin errors++; $display("FAIL rand_ready got %b want %b", ur, q.size() < 4); end
      checks++; if (af !== (q.size() >= 3)) begin errors++; $display("FAIL rand_af got %b want %b", af, q.size() >= 3); end
      checks++; if (dv !== (q.size() != 0)) begin errors++; $display("FAIL rand_valid got %b want %b", dv, q.size() != 0); end
      if (dv && dr) begin
        checks++; if (dd !== q[0]) begin errors++; $display("FAIL rand_data got %h want %h", dd, q[0]); end
        got++;
      end
      acc = uv && (q.size() < 4);
      adv(); cyc++;
    end
    checks++; if (got < 200) begin errors++; $display("FAIL rand_timeout got %0d want 200", got); end
    uv = 1'b0; dr = 1'b1;
    while (q.size() != 0) adv();
  endtask

  task automatic test_flush();
    dr = 1'b0; uv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ud = 8'h30 + 8'(i); adv();
    end
    checks++; if (cnt !== 3'd3) begin errors++; $display("FAIL flush_pre got %0d want 3", cnt); end
    flush = 1'b1; ud = 8'hEE;
    adv();
    flush = 1'b0; uv = 1'b0;
    checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL flush_count got %0d want 0", cnt); end
    checks++; if (dv !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", dv); end
    checks++; if (ur !== 1'b1) begin errors++; $display("FAIL flush_ready got %b want 1", ur); end
    checks++; if (af !== 1'b0) begin errors++; $display("FAIL flush_af got %b want 0", af); end
    uv = 1'b1; ud = 8'h77; dr = 1'b1;
    adv();
    uv = 1'b0;
    checks++; if (dv !== 1'b1 || dd !== 8'h77) begin errors++; $display("FAIL flush_next got %b/%h want 1/77", dv, dd); end
    adv();
    checks++; if (dv !== 1'b0) begin errors++; $display("FAIL flush_tail got %b want 0", dv); end
  endtask

  task automatic test_params();
    int gb = 0, gc = 0, cyc = 0;
    bit ab = 1'b1, ac = 1'b1;
    bit pb, pc, ob, oc;
    uv = 1'b0; dr = 1'b1;
    while ((gb < 40 || gc < 60) && cyc < 4000) begin
      b_dr = 1'($urandom_range(0, 1));
      c_dr = 1'($urandom_range(0, 1));
      if (ab || !b_uv) begin b_uv = 1'($urandom_range(0, 1)); b_ud = 1'($urandom); end
      if (ac || !c_uv) begin c_uv = 1'($urandom_range(0, 1)); c_ud = {$urandom, $urandom}; end
      checks++; if (b_cnt !== 2'(qb.size())) begin errors++; $display("FAIL d2_count got %0d want %0d", b_cnt, qb.size()); end
      checks++; if (b_af !== (qb.size() == 2)) begin errors++; $display("FAIL d2_af got %b want %b", b_af, qb.size() == 2); end
      checks++; if (c_cnt !== 3'(qc.size())) begin errors++; $display("FAIL d7_count got %0d want %0d", c_cnt, qc.size()); end
      checks++; if (c_af !== (qc.size() == 7)) begin errors++; $display("FAIL d7_af got %b want %b", c_af, qc.size() == 7); end
      pb = b_uv && (qb.size() < 2);
      ob = (qb.size() != 0) && b_dr;
      pc = c_uv && (qc.size() < 7);
      oc = (qc.size() != 0) && c_dr;
      if (ob) begin
        checks++; if (64'(b_dd) !== qb[0]) begin errors++; $display("FAIL d2_data got %h want %h", b_dd, qb[0]); end
        void'(qb.pop_front()); gb++;
      end
      if (oc) begin
        checks++; if (c_dd !== qc[0]) begin errors++; $display("FAIL d7_data got %h want %h", c_dd, qc[0]); end
        void'(qc.pop_front()); gc++;
      end
      if (pb) qb.push_back(64'(b_ud));
      if (pc) qc.push_back(c_ud);
      ab = pb; ac = pc;
      @(posedge clk); #1; cyc++;
    end
    checks++; if (gb < 40 || gc < 60) begin errors++; $display("FAIL param_timeout got %0d/%0d want 40/60", gb, gc); end
    b_uv = 1'b0; c_uv = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_simul();
    test_random();
    test_flush();
    test_params();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
